// File: rtl/tick_recover_if.sv
// Bundle between the divider outputs, tick_recover and the game logic.
// Latency: none, this is wiring only.
// Backpressure: game_req is held until game_ack; there are no other stalls.
interface tick_recover_if #(
  parameter int FRAME_W = 16,
  parameter int OVR_W   = 8
);
  logic               clk_blink_in;
  logic               clk_game_in;
  logic               clk_fast_in;
  logic               blink_state;
  logic               fast_tick;
  logic               game_tick;
  logic               game_req;
  logic               game_ack;
  logic [FRAME_W-1:0] frame_count;
  logic [OVR_W-1:0]   overrun_count;
  logic               game_stall;

  // Recovery block side: samples the raw waves and the ack, drives the results.
  modport master (
    input  clk_blink_in, clk_game_in, clk_fast_in, game_ack,
    output blink_state, fast_tick, game_tick, game_req,
           frame_count, overrun_count, game_stall
  );

  // Environment side: the divider drives the waves, game logic acknowledges.
  modport slave (
    output clk_blink_in, clk_game_in, clk_fast_in, game_ack,
    input  blink_state, fast_tick, game_tick, game_req,
           frame_count, overrun_count, game_stall
  );
endinterface

// File: rtl/tick_recover.sv
// Recovers divided square waves into clock_in-domain levels, tick pulses and a frame req/ack.
// Latency: level SYNC_STAGES-1 edges after first sample, tick SYNC_STAGES edges after.
// Backpressure: a frame arriving while game_req is still set is counted as an overrun.
module tick_recover #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [27:0] WDOG_LIMIT  = 28'd2500000,
  parameter int          FRAME_W     = 16,
  parameter int          OVR_W       = 8
) (
  input  logic           clock_in,
  input  logic           rst,
  tick_recover_if.master bus
);

  // Channel bit order used throughout: [2] fast, [1] game, [0] blink.
  localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

  logic [2:0]         sync_q [SYNC_STAGES];
  logic [2:0]         hist_q;
  logic [2:0]         lvl;
  logic [2:0]         rise;
  logic [2:0]         arm_cnt;
  logic               armed;
  logic               fast_tick_q;
  logic               game_tick_q;
  logic               game_req_q;
  logic [FRAME_W-1:0] frame_cnt;
  logic [OVR_W-1:0]   ovr_cnt;
  logic [27:0]        wdog_cnt;
  logic               stall_q;

  assign lvl   = sync_q[SYNC_STAGES-1];
  // Until the chain has flushed, a level that was already high at reset release
  // would look like a rising edge, so edges are suppressed until armed.
  assign armed = (arm_cnt == ARM_MAX);
  assign rise  = armed ? (lvl & ~hist_q) : 3'b000;

  // Synchronizer chains and edge-history flops for all three channels.
  always_ff @(posedge clock_in) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 3'b000;
      hist_q <= 3'b000;
    end else begin
      sync_q[0] <= {bus.clk_fast_in, bus.clk_game_in, bus.clk_blink_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q <= lvl;
    end
  end

  // Arm counter: counts up after reset release and parks at ARM_MAX.
  always_ff @(posedge clock_in) begin
    if (rst)         arm_cnt <= 3'd0;
    else if (!armed) arm_cnt <= arm_cnt + 3'd1;
  end

  // Registered single-cycle tick pulses.
  always_ff @(posedge clock_in) begin
    if (rst) begin
      fast_tick_q <= 1'b0;
      game_tick_q <= 1'b0;
    end else begin
      fast_tick_q <= rise[2];
      game_tick_q <= rise[1];
    end
  end

  // Frame handshake: a new frame (re)asserts req; an ack with no new frame retires it.
  always_ff @(posedge clock_in) begin
    if (rst) begin
      game_req_q <= 1'b0;
      frame_cnt  <= '0;
      ovr_cnt    <= '0;
    end else if (rise[1]) begin
      frame_cnt  <= frame_cnt + FRAME_W'(1);
      game_req_q <= 1'b1;
      if (game_req_q && !bus.game_ack && (ovr_cnt != '1))
        ovr_cnt <= ovr_cnt + OVR_W'(1);
    end else if (game_req_q && bus.game_ack) begin
      game_req_q <= 1'b0;
    end
  end

  // Watchdog: stall is raised on the same edge the counter reaches the limit.
  always_ff @(posedge clock_in) begin
    if (rst) begin
      wdog_cnt <= 28'd0;
      stall_q  <= 1'b0;
    end else if (rise[1]) begin
      wdog_cnt <= 28'd0;
      stall_q  <= 1'b0;
    end else if (armed) begin
      if (wdog_cnt != WDOG_LIMIT)          wdog_cnt <= wdog_cnt + 28'd1;
      if (wdog_cnt >= WDOG_LIMIT - 28'd1)  stall_q  <= 1'b1;
    end
  end

  assign bus.blink_state   = lvl[0];
  assign bus.fast_tick     = fast_tick_q;
  assign bus.game_tick     = game_tick_q;
  assign bus.game_req      = game_req_q;
  assign bus.frame_count   = frame_cnt;
  assign bus.overrun_count = ovr_cnt;
  assign bus.game_stall    = stall_q;

endmodule

// File: tb/tb_tick_recover.sv
// Bench for tick_recover: scoreboarded game frames plus per-feature directed scenarios.
// Latency: inputs change 1ns after a clock edge, outputs are sampled 1ns after it.
// Backpressure: game_ack is driven either automatically or per scenario.
module tb_tick_recover;

  localparam int          FRAME_W = 16;
  localparam int          OVR_W   = 8;
  localparam logic [27:0] WDOG    = 28'd50;

  logic clock_in = 1'b0;
  logic rst      = 1'b1;

  tick_recover_if #(.FRAME_W(FRAME_W), .OVR_W(OVR_W)) bus ();

  tick_recover #(
    .SYNC_STAGES(2),
    .WDOG_LIMIT (WDOG),
    .FRAME_W    (FRAME_W),
    .OVR_W      (OVR_W)
  ) dut (
    .clock_in(clock_in),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clock_in = ~clock_in;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_no   = 0;
  int last_game_tick = -1;
  int n_game_ticks = 0;
  int n_fast_ticks = 0;

  logic [FRAME_W-1:0] exp_q [$];
  logic [FRAME_W-1:0] m_frame = '0;

  bit   auto_ack = 1'b0;
  int   ack_cnt  = 0;
  logic prev_req = 1'b0;

  // One clock: sample outputs 1ns after the edge, pop the scoreboard on game_tick.
  task automatic cyc();
    logic [FRAME_W-1:0] e;
    @(posedge clock_in);
    #1;
    cyc_no++;
    if (bus.fast_tick) n_fast_ticks++;
    if (bus.game_tick) begin
      n_game_ticks++;
      last_game_tick = cyc_no;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_tick: got tick with frame_count=%0d, required no tick", bus.frame_count);
      end else begin
        e = exp_q.pop_front();
        if (bus.frame_count !== e) begin
          n_fail++;
          $display("FAIL sb_frame_count: got %0d, required %0d", bus.frame_count, e);
        end
      end
    end
    if (auto_ack) begin
      bus.game_ack = 1'b0;
      if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) bus.game_ack = 1'b1;
      end
      if (bus.game_req && !prev_req) ack_cnt = 3;
    end
    prev_req = bus.game_req;
  endtask

  task automatic game_rise();
    bus.clk_game_in = 1'b1;
    m_frame = m_frame + FRAME_W'(1);
    exp_q.push_back(m_frame);
  endtask

  task automatic game_period();
    game_rise();
    repeat (10) cyc();
    bus.clk_game_in = 1'b0;
    repeat (10) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    exp_q.delete();
    m_frame = '0;
    prev_req = 1'b0;
    ack_cnt = 0;
    bus.game_ack = 1'b0;
    repeat (6) cyc();
  endtask

  // Game frame whose ack lands on the very edge the frame is registered.
  task automatic sim_ack_frame(input logic [OVR_W-1:0] exp_ovr);
    game_rise();
    cyc();
    cyc();
    bus.game_ack = 1'b1;
    cyc();
    bus.game_ack = 1'b0;
    n_checks++;
    if (bus.game_tick !== 1'b1) begin
      n_fail++; $display("FAIL simack_tick_align: got %b, required 1", bus.game_tick);
    end
    n_checks++;
    if (bus.game_req !== 1'b1) begin
      n_fail++; $display("FAIL simack_req: got %b, required 1", bus.game_req);
    end
    n_checks++;
    if (bus.overrun_count !== exp_ovr) begin
      n_fail++; $display("FAIL simack_ovr: got %0d, required %0d", bus.overrun_count, exp_ovr);
    end
    repeat (7) cyc();
    bus.clk_game_in = 1'b0;
    repeat (10) cyc();
    n_checks++;
    if (bus.game_req !== 1'b1) begin
      n_fail++; $display("FAIL simack_req_held: got %b, required 1", bus.game_req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.clk_game_in = 1'b1;
    repeat (3) cyc();
    n_checks++;
    if ({bus.blink_state, bus.fast_tick, bus.game_tick, bus.game_req, bus.game_stall} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b, required 00000",
        {bus.blink_state, bus.fast_tick, bus.game_tick, bus.game_req, bus.game_stall});
    end
    n_checks++;
    if (bus.frame_count !== '0 || bus.overrun_count !== '0) begin
      n_fail++; $display("FAIL reset_counts: got frame=%0d ovr=%0d, required 0 0",
        bus.frame_count, bus.overrun_count);
    end
    rst = 1'b0;
    repeat (12) cyc();
    n_checks++;
    if (n_game_ticks !== 0) begin
      n_fail++; $display("FAIL arm_no_tick: got %0d ticks, required 0", n_game_ticks);
    end
    n_checks++;
    if (bus.frame_count !== '0) begin
      n_fail++; $display("FAIL arm_frame: got %0d, required 0", bus.frame_count);
    end
    n_checks++;
    if (bus.game_req !== 1'b0) begin
      n_fail++; $display("FAIL arm_req: got %b, required 0", bus.game_req);
    end
    bus.clk_game_in = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic test_latency();
    int first;
    int high;
    repeat (10) cyc();
    first = -1;
    high = 0;
    bus.clk_fast_in = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      cyc();
      if (bus.fast_tick) begin
        high++;
        if (first < 0) first = j;
      end
    end
    n_checks++;
    if (first !== 3) begin
      n_fail++; $display("FAIL fast_latency: got first tick at %0d, required 3", first);
    end
    n_checks++;
    if (high !== 1) begin
      n_fail++; $display("FAIL fast_width: got %0d cycles high, required 1", high);
    end
    high = 0;
    bus.clk_fast_in = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      cyc();
      if (bus.fast_tick) high++;
    end
    n_checks++;
    if (high !== 0) begin
      n_fail++; $display("FAIL fast_falling: got %0d pulses, required 0", high);
    end
    bus.clk_blink_in = 1'b1;
    cyc();
    n_checks++;
    if (bus.blink_state !== 1'b0) begin
      n_fail++; $display("FAIL blink_early: got %b, required 0", bus.blink_state);
    end
    cyc();
    n_checks++;
    if (bus.blink_state !== 1'b1) begin
      n_fail++; $display("FAIL blink_rise: got %b, required 1", bus.blink_state);
    end
    bus.clk_blink_in = 1'b0;
    repeat (2) cyc();
    n_checks++;
    if (bus.blink_state !== 1'b0) begin
      n_fail++; $display("FAIL blink_fall: got %b, required 0", bus.blink_state);
    end
  endtask

  task automatic test_simultaneous();
    int fj;
    int gj;
    fj = -1;
    gj = -1;
    bus.clk_fast_in = 1'b1;
    bus.clk_blink_in = 1'b1;
    game_rise();
    for (int j = 1; j <= 6; j++) begin
      cyc();
      if (bus.fast_tick && fj < 0) fj = j;
      if (bus.game_tick && gj < 0) gj = j;
    end
    n_checks++;
    if (fj !== 3 || gj !== 3) begin
      n_fail++; $display("FAIL simultaneous: got fast@%0d game@%0d, required both @3", fj, gj);
    end
    bus.clk_fast_in = 1'b0;
    bus.clk_blink_in = 1'b0;
    bus.clk_game_in = 1'b0;
    repeat (10) cyc();
  endtask

  task automatic test_handshake();
    do_reset();
    auto_ack = 1'b1;
    for (int p = 0; p < 5; p++) begin
      n_checks++;
      if (bus.game_req !== 1'b0) begin
        n_fail++; $display("FAIL hs_req_idle: frame %0d got %b, required 0", p, bus.game_req);
      end
      game_period();
    end
    auto_ack = 1'b0;
    bus.game_ack = 1'b0;
    n_checks++;
    if (bus.frame_count !== 16'd5) begin
      n_fail++; $display("FAIL hs_frames: got %0d, required 5", bus.frame_count);
    end
    n_checks++;
    if (bus.overrun_count !== 8'd0) begin
      n_fail++; $display("FAIL hs_ovr: got %0d, required 0", bus.overrun_count);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    game_period();
    sim_ack_frame(8'd0);
    game_period();
    n_checks++;
    if (bus.overrun_count !== 8'd1) begin
      n_fail++; $display("FAIL ovr_first: got %0d, required 1", bus.overrun_count);
    end
    for (int p = 3; p < 300; p++) game_period();
    n_checks++;
    if (bus.frame_count !== 16'd300) begin
      n_fail++; $display("FAIL ovr_frames: got %0d, required 300", bus.frame_count);
    end
    n_checks++;
    if (bus.overrun_count !== 8'd255) begin
      n_fail++; $display("FAIL ovr_sat: got %0d, required 255", bus.overrun_count);
    end
    n_checks++;
    if (bus.game_req !== 1'b1) begin
      n_fail++; $display("FAIL ovr_req: got %b, required 1", bus.game_req);
    end
    sim_ack_frame(8'd255);
  endtask

  task automatic test_watchdog();
    int rise_cyc;
    logic prev_stall;
    int tick_seen;
    rise_cyc = -1;
    for (int j = 0; j < 200 && rise_cyc < 0; j++) begin
      cyc();
      if (bus.game_stall) rise_cyc = cyc_no;
    end
    n_checks++;
    if (rise_cyc < 0 || (rise_cyc - last_game_tick) !== 50) begin
      n_fail++; $display("FAIL wdog_delay: got %0d cycles after tick, required 50",
        (rise_cyc < 0) ? -1 : rise_cyc - last_game_tick);
    end
    repeat (30) cyc();
    n_checks++;
    if (bus.game_stall !== 1'b1) begin
      n_fail++; $display("FAIL wdog_sticky: got %b, required 1", bus.game_stall);
    end
    game_rise();
    prev_stall = bus.game_stall;
    tick_seen = 0;
    for (int j = 0; j < 8 && tick_seen == 0; j++) begin
      cyc();
      if (bus.game_tick) begin
        tick_seen = 1;
        n_checks++;
        if (bus.game_stall !== 1'b0 || prev_stall !== 1'b1) begin
          n_fail++; $display("FAIL wdog_clear: got stall %b (before %b), required 0 (before 1)",
            bus.game_stall, prev_stall);
        end
      end
      prev_stall = bus.game_stall;
    end
    if (tick_seen == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL wdog_resume_timeout: got no game_tick in 8 cycles, required one");
    end
    repeat (7) cyc();
    bus.clk_game_in = 1'b0;
    repeat (10) cyc();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int p = 0; p < 7; p++) game_period();
    repeat (60) cyc();
    n_checks++;
    if (bus.game_req !== 1'b1 || bus.frame_count !== 16'd7 || bus.game_stall !== 1'b1) begin
      n_fail++; $display("FAIL mid_setup: got req=%b frame=%0d stall=%b, required 1 7 1",
        bus.game_req, bus.frame_count, bus.game_stall);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_checks++;
    if ({bus.game_req, bus.game_stall, bus.game_tick, bus.fast_tick, bus.blink_state} !== 5'b0 ||
        bus.frame_count !== '0 || bus.overrun_count !== '0) begin
      n_fail++; $display("FAIL mid_reset: got req=%b stall=%b frame=%0d ovr=%0d, required all 0",
        bus.game_req, bus.game_stall, bus.frame_count, bus.overrun_count);
    end
    exp_q.delete();
    m_frame = '0;
    repeat (6) cyc();
    game_period();
    n_checks++;
    if (bus.frame_count !== 16'd1 || bus.game_req !== 1'b1 || bus.overrun_count !== 8'd0) begin
      n_fail++; $display("FAIL mid_restart: got frame=%0d req=%b ovr=%0d, required 1 1 0",
        bus.frame_count, bus.game_req, bus.overrun_count);
    end
  endtask

  initial begin
    bus.clk_blink_in = 1'b0;
    bus.clk_game_in  = 1'b0;
    bus.clk_fast_in  = 1'b0;
    bus.game_ack     = 1'b0;
    test_reset();
    test_latency();
    test_simultaneous();
    test_handshake();
    test_overrun();
    test_watchdog();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++; $display("FAIL sb_drain: got %0d frames outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tick_recover.md
Name: tick_recover

Overview:
- Consumer end of the clock-divider outputs.
- Takes the slow divided square waves (blink, game, fast) and samples them in the 100 MHz `clock_in` domain.
- Converts them into synchronized levels, single-cycle enable pulses, and a req/ack frame handshake for game logic, so downstream logic runs on `clock_in` instead of on derived clocks.
- Also counts frames, counts missed (unacknowledged) frames, and flags a stalled game clock.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops per input (legal range 2..4).
- WDOG_LIMIT, 28'd2500000, `clock_in` cycles with no game rising edge before `game_stall` is set.
- FRAME_W, 16, width of `frame_count`.
- OVR_W, 8, width of `overrun_count`.

Ports:
- clock_in  in  1  100 MHz master clock.
- rst  in  1  synchronous reset, active high.
- clk_blink_in  in  1  divided blink square wave, asynchronous to clock_in.
- clk_game_in  in  1  divided game square wave, asynchronous.
- clk_fast_in  in  1  divided fast square wave, asynchronous.
- blink_state  out  1  synchronized level of clk_blink_in.
- fast_tick  out  1  one-cycle pulse per rising edge of clk_fast_in.
- game_tick  out  1  one-cycle pulse per rising edge of clk_game_in.
- game_req  out  1  frame-pending request, held until acknowledged.
- game_ack  in  1  frame consumed; sampled only while game_req=1.
- frame_count  out  FRAME_W  game rising edges since reset, wraps.
- overrun_count  out  OVR_W  frames arriving while game_req was already set, saturating.
- game_stall  out  1  game clock stalled; sticky until the next game edge.

Behaviour:
- All state updates on posedge clock_in. rst=1 at an edge clears everything on that edge.
- Reset values:
  - all synchronizer flops and edge-history flops 0.
  - blink_state, fast_tick, game_tick, game_req, game_stall all 0.
  - frame_count 0, overrun_count 0, watchdog counter 0, arm counter 0.
- Synchronizer: each input passes through SYNC_STAGES flops. The last stage is the synchronized level L.
  - blink_state = L_blink, registered.
  - If an input is first sampled high at edge k, blink_state is 1 after edge k+SYNC_STAGES-1.
- Edge detect: a history flop H holds the previous L. Rising edge r = L & ~H.
  - fast_tick and game_tick are registered r: high for exactly one cycle, after edge k+SYNC_STAGES.
  - Falling edges produce nothing.
- Arming: the arm counter counts cycles after rst deasserts, up to SYNC_STAGES+1.
  - Until it reaches SYNC_STAGES+1, r is forced to 0 on all channels.
  - The watchdog does not count during this window.
  - Purpose: an input already high at reset release must not produce a spurious tick.
- Game handshake, evaluated on a cycle where game r=1:
  - frame_count increments, wrapping at 2^FRAME_W.
  - If game_req=0: game_req becomes 1.
  - If game_req=1 and game_ack=0: game_req stays 1 and overrun_count increments, saturating at 2^OVR_W-1.
  - If game_req=1 and game_ack=1 (simultaneous): game_req stays 1 (the new frame is pending) and there is no overrun.
- Game handshake, no game edge:
  - game_req=1 and game_ack=1: game_req becomes 0 next edge.
  - game_ack while game_req=0: ignored.
- Watchdog:
  - The counter resets to 0 on any game r=1.
  - Otherwise it increments and saturates at WDOG_LIMIT.
  - When the counter equals WDOG_LIMIT, game_stall is set to 1 and stays set.
  - The next game r=1 clears game_stall and the counter in the same edge.
- Channels are independent. Simultaneous edges on all three inputs produce simultaneous pulses.
- Input pulses shorter than one clock_in period may be missed; no requirement applies to them.
- rst asserted mid-handshake drops game_req and discards the pending frame.

Test Plan:
1. Reset/arm:
   - Stimulus: hold clk_game_in=1 through rst; deassert rst.
   - Required: no game_tick, frame_count stays 0, game_req stays 0.
2. Latency/pulse width:
   - Stimulus: rst released; wait 10 cycles; raise clk_fast_in and hold it high 20 cycles.
   - Required:
     - fast_tick high exactly one cycle, first high after edge k+2 (SYNC_STAGES=2).
     - blink_state follows clk_blink_in after 2 edges.
3. Handshake:
   - Stimulus: game square wave with period 20; ack 3 cycles after each game_req rise.
   - Required: after 5 edges, frame_count=5, overrun_count=0, game_req low between frames.
4. Overrun and simultaneous ack:
   - Stimulus: never ack; 300 game edges.
   - Required: frame_count=300, overrun_count=255 (saturated), game_req=1.
   - Then: assert game_ack in the same cycle as game_tick. Required: game_req stays 1 and overrun_count is unchanged.
5. Watchdog:
   - Stimulus: WDOG_LIMIT=50; stop clk_game_in toggling.
   - Required: game_stall rises 50 cycles after the last game_tick.
   - Then: resume toggling. Required: game_stall clears on the cycle game_tick is high.
6. Reset mid-operation:
   - Stimulus: game_req=1, frame_count=7, game_stall=1; pulse rst for one cycle.
   - Required: all outputs return to 0 the next cycle; counting restarts from 0.
